ps2_rx_frame: RTL and testbench

- Parametrised PS/2 device-to-host frame receiver. It replaces the raw negedge-clocked serial-in shift register with a fully synchronous design.
- Samples ps2c/ps2d in the system clock domain, glitch-filters ps2c, and sequences start/data/parity/stop bits.
- Checks framing and parity, then presents the data word on a valid/ready interface.
- Sits between the PS/2 pads and the keyboard/mouse scan-code decoder.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_line_filter.sv | 64 ++++++
 rtl/ps2_rx_frame.sv | 187 ++++++++++++++++++
 tb/tb_ps2_rx_frame.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 receive path.
// Holds the frame FSM state encoding, the fixed start/stop bit levels
// and the parity helper used to validate received frames.
package ps2_pkg;

  // Receive FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_rx_state_e;

  // Line levels of the framing bits on a PS/2 bus
  localparam logic PS2_START_BIT = 1'b0;
  localparam logic PS2_STOP_BIT  = 1'b1;

  // Widest data word the receiver supports
  localparam int PS2_MAX_DATA_W = 9;

  // Returns the parity bit a well-formed frame must carry for 'data'.
  // Narrower words are zero-extended, which leaves the XOR unchanged.
  function automatic logic ps2_parity(input logic [PS2_MAX_DATA_W-1:0] data,
                                      input logic                      odd);
    return odd ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioning: two-flop synchronisers on clock and data,
// a persistence filter on the clock line and a one-cycle strobe on each
// filtered falling edge.  'd_s' is the synchronised data, valid to sample
// in the same cycle 'fall' is high.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2c,
  input  logic ps2d,
  output logic fall,
  output logic d_s
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic             c_meta_q, c_sync_q;
  logic             d_meta_q, d_sync_q;
  logic             fc_q, fc_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Filtered clock follows the synchronised clock only after it has
  // disagreed for FILTER_LEN consecutive cycles; any agreement restarts it.
  always_comb begin
    fc_d  = fc_q;
    cnt_d = '0;
    if (c_sync_q != fc_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        fc_d  = c_sync_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    fall_d = fc_q & ~fc_d;
  end

  // Synchronisers, filter state and edge strobe; bus idles high after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_meta_q <= 1'b1;
      c_sync_q <= 1'b1;
      d_meta_q <= 1'b1;
      d_sync_q <= 1'b1;
      fc_q     <= 1'b1;
      cnt_q    <= '0;
      fall_q   <= 1'b0;
    end else begin
      c_meta_q <= ps2c;
      c_sync_q <= c_meta_q;
      d_meta_q <= ps2d;
      d_sync_q <= d_meta_q;
      fc_q     <= fc_d;
      cnt_q    <= cnt_d;
      fall_q   <= fall_d;
    end
  end

  assign fall = fall_q;
  assign d_s  = d_sync_q;

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver, fully synchronous to 'clk'.
// Sequences start/data/parity/stop on filtered falling edges, checks the
// framing and parity, and hands good words out on a valid/ready port.
// Optional error counter: define PS2_RX_ERR_CNT_EN to add err_clr/err_cnt.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 5000,
  parameter int ODD_PARITY  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ps2c,
  input  logic              ps2d,
  input  logic              ce,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun
`ifdef PS2_RX_ERR_CNT_EN
  ,
  input  logic              err_clr,
  output logic [7:0]        err_cnt
`endif
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic fall;
  logic d_s;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_line_filter (
    .clk  (clk),
    .rst_n(rst_n),
    .ps2c (ps2c),
    .ps2d (ps2d),
    .fall (fall),
    .d_s  (d_s)
  );

  ps2_rx_state_e     state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              parity_err_q, parity_err_d;
  logic              overrun_q, overrun_d;
  logic              par_exp;

  assign par_exp = ps2_parity(PS2_MAX_DATA_W'(shift_q), ODD_PARITY != 0);

  // Next-state logic: enable abort, then bit sequencing on each filtered
  // fall, then the mid-frame timeout.  Handshake clear runs underneath so
  // a new good word arriving on the accept cycle simply reloads.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    overrun_d    = 1'b0;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    if (state_q == IDLE || fall) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end

    if (!ce) begin
      state_d  = IDLE;
      to_cnt_d = '0;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          if (d_s == PS2_START_BIT) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d   = {d_s, shift_q[DATA_W-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'(DATA_W - 1)) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          par_d   = d_s;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (d_s != PS2_STOP_BIT) begin
            frame_err_d = 1'b1;
          end else if (par_q != par_exp) begin
            parity_err_d = 1'b1;
          end else if (rx_valid_q && !rx_ready) begin
            overrun_d = 1'b1;
          end else begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
      to_cnt_d    = '0;
    end
  end

  // Frame FSM, timeout counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      to_cnt_q     <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      to_cnt_q     <= to_cnt_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

`ifdef PS2_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating tally of error pulses; a clear request beats an increment
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if ((frame_err_q || parity_err_q || overrun_q) && err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Error counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Self-checking bench for ps2_rx_frame: a table of whole frames with
// hand-computed results, plus directed sequences for reset, glitch
// rejection, timeout and receive-enable abort.
module tb_ps2_rx_frame;

  localparam int DATA_W      = 8;
  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 300;
  localparam int HALF        = 20;

  logic              clk;
  logic              rst_n;
  logic              ps2c;
  logic              ps2d;
  logic              ce;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              frame_err;
  logic              parity_err;
  logic              overrun;
`ifdef PS2_RX_ERR_CNT_EN
  logic              err_clr;
  logic [7:0]        err_cnt;
`endif

  ps2_rx_frame #(
    .DATA_W     (DATA_W),
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .ODD_PARITY (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2c      (ps2c),
    .ps2d      (ps2d),
    .ce        (ce),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun)
`ifdef PS2_RX_ERR_CNT_EN
    ,
    .err_clr   (err_clr),
    .err_cnt   (err_cnt)
`endif
  );

  // Free-running system clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;
  int ferrTotal  = 0;
  int perrTotal  = 0;
  int ovrTotal   = 0;

  // Tally every error pulse the DUT emits so frames can be judged by delta
  always @(posedge clk) begin
    if (rst_n) begin
      if (frame_err)  ferrTotal++;
      if (parity_err) perrTotal++;
      if (overrun)    ovrTotal++;
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       flipPar;
    logic       stopBit;
    logic       accept;
    logic       expValid;
    logic [7:0] expData;
    int         expFerr;
    int         expPerr;
    int         expOvr;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One PS/2 bit: data set while clock high, then a full low/high clock
  task automatic sendBit(input logic b);
    @(negedge clk);
    ps2d = b;
    waitCycles(HALF);
    ps2c = 1'b0;
    waitCycles(HALF);
    ps2c = 1'b1;
  endtask

  task automatic sendFrame(input logic [7:0] data, input logic par, input logic stopBit);
    sendBit(1'b0);
    for (int i = 0; i < DATA_W; i++) sendBit(data[i]);
    sendBit(par);
    sendBit(stopBit);
    ps2d = 1'b1;
    waitCycles(HALF);
  endtask

  // Odd-parity bit for a correct frame, found by counting set bits
  function automatic logic oddPar(input logic [7:0] data);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (data[i]) ones++;
    return (ones % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic acceptWord(input string name);
    @(negedge clk);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput({name, "_accept_clear"}, 32'(rx_valid), 32'd0);
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int f0, p0, o0;
    string tag;
    f0 = ferrTotal; p0 = perrTotal; o0 = ovrTotal;
    tag = $sformatf("vec%0d", idx);
    sendFrame(v.data, oddPar(v.data) ^ v.flipPar, v.stopBit);
    checkOutput({tag, "_valid"}, 32'(rx_valid), 32'(v.expValid));
    checkOutput({tag, "_data"}, 32'(rx_data), 32'(v.expData));
    checkOutput({tag, "_frame_err"}, 32'(ferrTotal - f0), 32'(v.expFerr));
    checkOutput({tag, "_parity_err"}, 32'(perrTotal - p0), 32'(v.expPerr));
    checkOutput({tag, "_overrun"}, 32'(ovrTotal - o0), 32'(v.expOvr));
    if (v.accept) acceptWord(tag);
  endtask

  initial begin
    int f0, p0, o0;

    //          data   flip stop acc  valid data   ferr perr ovr
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b1, 8'h1C, 0, 0, 0};
    vecs[1] = '{8'hF0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h1C, 0, 1, 0};
    vecs[2] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h1C, 1, 0, 0};
    vecs[3] = '{8'h5A, 1'b0, 1'b1, 1'b1, 1'b1, 8'h5A, 0, 0, 0};
    vecs[4] = '{8'h12, 1'b0, 1'b1, 1'b0, 1'b1, 8'h12, 0, 0, 0};
    vecs[5] = '{8'h34, 1'b0, 1'b1, 1'b1, 1'b1, 8'h12, 0, 0, 1};
    vecs[6] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 0, 0, 0};
    vecs[7] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 0, 0, 0};

    rst_n    = 1'b0;
    ps2c     = 1'b1;
    ps2d     = 1'b1;
    ce       = 1'b1;
    rx_ready = 1'b0;
`ifdef PS2_RX_ERR_CNT_EN
    err_clr  = 1'b0;
`endif
    waitCycles(5);
    checkOutput("reset_valid", 32'(rx_valid), 32'd0);
    checkOutput("reset_data", 32'(rx_data), 32'd0);
    checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
    checkOutput("reset_parity_err", 32'(parity_err), 32'd0);
    checkOutput("reset_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    waitCycles(5);

    // Short clock glitch with data low must not start a frame
    f0 = ferrTotal; p0 = perrTotal; o0 = ovrTotal;
    @(negedge clk);
    ps2d = 1'b0;
    ps2c = 1'b0;
    waitCycles(FILTER_LEN - 2);
    ps2c = 1'b1;
    waitCycles(HALF);
    ps2d = 1'b1;
    waitCycles(HALF);
    checkOutput("glitch_valid", 32'(rx_valid), 32'd0);
    checkOutput("glitch_errs", 32'((ferrTotal - f0) + (perrTotal - p0) + (ovrTotal - o0)), 32'd0);
    sendFrame(8'h77, oddPar(8'h77), 1'b1);
    checkOutput("glitch_next_valid", 32'(rx_valid), 32'd1);
    checkOutput("glitch_next_data", 32'(rx_data), 32'h77);
    acceptWord("glitch_next");

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

    // Clock stalls after four data bits: exactly one timeout error
    f0 = ferrTotal;
    sendBit(1'b0);
    for (int i = 0; i < 4; i++) sendBit(1'(i & 1));
    ps2d = 1'b1;
    waitCycles(TIMEOUT_CYC + 10);
    checkOutput("timeout_frame_err", 32'(ferrTotal - f0), 32'd1);
    checkOutput("timeout_valid", 32'(rx_valid), 32'd0);
    sendFrame(8'h29, oddPar(8'h29), 1'b1);
    checkOutput("timeout_next_valid", 32'(rx_valid), 32'd1);
    checkOutput("timeout_next_data", 32'(rx_data), 32'h29);
    acceptWord("timeout_next");

    // Dropping receive enable mid-frame aborts silently
    f0 = ferrTotal; p0 = perrTotal;
    sendBit(1'b0);
    for (int i = 0; i < 3; i++) sendBit(1'b1);
    @(negedge clk);
    ce = 1'b0;
    waitCycles(5);
    ce = 1'b1;
    waitCycles(TIMEOUT_CYC + 10);
    checkOutput("ce_abort_errs", 32'((ferrTotal - f0) + (perrTotal - p0)), 32'd0);
    sendFrame(8'h3C, oddPar(8'h3C), 1'b1);
    checkOutput("ce_next_valid", 32'(rx_valid), 32'd1);
    checkOutput("ce_next_data", 32'(rx_data), 32'h3C);

    // Receive enable low keeps the held word
    @(negedge clk);
    ce = 1'b0;
    waitCycles(3);
    checkOutput("ce_hold_valid", 32'(rx_valid), 32'd1);
    checkOutput("ce_hold_data", 32'(rx_data), 32'h3C);
    ce = 1'b1;
    acceptWord("ce_next");

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
